// File: rtl/key_press_encoder_pkg.sv
// Shared definitions for the Simon Says button path: key count, code width,
// key index constants used by both this encoder and the display decoder,
// and the encoder FSM state encoding.
package simon_pkg;

  localparam int NUM_KEYS = 6;
  localparam int CODE_W   = 3;

  localparam logic [CODE_W-1:0] KEY_0 = 3'd0;
  localparam logic [CODE_W-1:0] KEY_1 = 3'd1;
  localparam logic [CODE_W-1:0] KEY_2 = 3'd2;
  localparam logic [CODE_W-1:0] KEY_3 = 3'd3;
  localparam logic [CODE_W-1:0] KEY_4 = 3'd4;
  localparam logic [CODE_W-1:0] KEY_5 = 3'd5;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    HELD = 2'd2
  } state_e;

endpackage

// File: rtl/key_press_encoder_if.sv
// Key code handshake towards the game FSM, plus the status flags that
// travel alongside it.
interface key_press_encoder_if #(
  parameter int CODE_W = 3
);
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ready;
  logic              key_held;
  logic              overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_held,
    output overrun,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_held,
    input  overrun,
    output key_ready
  );
endinterface

// File: rtl/key_press_encoder_debouncer.sv
// Two-flop synchroniser and shared-counter debouncer for the active-low
// button vector. db only follows the synchronised level once it has been
// stable for DEBOUNCE_CYCLES consecutive cycles; settled_o reports that the
// counter is saturated, i.e. db currently mirrors the synchronised input.
module key_debouncer #(
  parameter int NUM_KEYS        = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n_i,
  output logic [NUM_KEYS-1:0] db_o,
  output logic                settled_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] db_q, db_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] s_s;

  // sync1_q is the value s takes after the next edge, so a mismatch with
  // sync2_q means s changes on that edge and the stability count restarts.
  assign s_s = ~sync2_q;

  // Stability counter and the debounced level it gates.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync1_q != sync2_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    if ((cnt_q != CNT_MAX) && (cnt_d == CNT_MAX)) begin
      db_d = s_s;
    end else begin
      db_d = db_q;
    end
  end

  // Synchroniser, counter and debounced-vector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {NUM_KEYS{1'b0}};
      sync2_q <= {NUM_KEYS{1'b0}};
      cnt_q   <= CNT_ZERO;
      db_q    <= {NUM_KEYS{1'b0}};
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign db_o      = db_q;
  assign settled_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/key_press_encoder.sv
// Turns debounced Simon Says buttons into one key index per clean press,
// delivered through a single-entry valid/ready slot. Chords produce nothing;
// a press arriving while the slot is still full is dropped and flagged.
module key_press_encoder #(
  parameter int NUM_KEYS        = simon_pkg::NUM_KEYS,
  parameter int CODE_W          = simon_pkg::CODE_W,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  key_press_encoder_if.master key_if
);

  import simon_pkg::*;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

  // Index of the (highest) set bit of v.
  function automatic logic [CODE_W-1:0] key_index(input logic [NUM_KEYS-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = {CODE_W{1'b0}};
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) begin
        idx = CODE_W'(i);
      end
    end
    return idx;
  endfunction

  logic [NUM_KEYS-1:0] db_s;
  logic                settled_s;
  logic                emit_s;
  logic                accept_s;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                held_q;

  key_debouncer #(
    .NUM_KEYS        (NUM_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n_i   (key_n),
    .db_o      (db_s),
    .settled_o (settled_s)
  );

  // Press tracking. db is cleared by reset before the debouncer has seen the
  // buttons, so ARM also waits for the counter to settle: otherwise a key
  // held through reset would look like a fresh press once debounced.
  always_comb begin
    state_d = state_q;
    emit_s  = 1'b0;
    case (state_q)
      ARM: begin
        if (settled_s && (db_s == {NUM_KEYS{1'b0}})) begin
          state_d = IDLE;
        end else begin
          state_d = ARM;
        end
      end
      IDLE: begin
        if (db_s != {NUM_KEYS{1'b0}}) begin
          state_d = HELD;
          emit_s  = is_onehot(db_s);
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (db_s == {NUM_KEYS{1'b0}}) begin
          state_d = IDLE;
        end else begin
          state_d = HELD;
        end
      end
      default: begin
        state_d = ARM;
      end
    endcase
  end

  // Single-entry output slot; an accept on the emit cycle frees room for it.
  always_comb begin
    accept_s  = valid_q & key_if.key_ready;
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (emit_s) begin
      if (!valid_q || accept_s) begin
        code_d  = key_index(db_s);
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARM;
      code_q    <= {CODE_W{1'b0}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      held_q    <= |db_s;
    end
  end

  assign key_if.key_code  = code_q;
  assign key_if.key_valid = valid_q;
  assign key_if.overrun   = overrun_q;
  assign key_if.key_held  = held_q;

endmodule

// File: tb/tb_key_press_encoder.sv
// Self-checking bench for key_press_encoder with a short debounce window.
// A behavioural model (sample-window debounce, press/release tracking and a
// one-entry slot) is compared against the DUT every cycle, with directed
// checks for latency, bounce, overrun, chords and reset behaviour.
module tb_key_press_encoder;

  localparam int DEB = 4;
  localparam int NK  = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_n;

  int n_assert = 0;
  int n_fail   = 0;
  int rises    = 0;
  int ovr_cnt  = 0;
  logic prev_valid = 1'b0;

  key_press_encoder_if #(.CODE_W(3)) kif ();

  key_press_encoder #(
    .NUM_KEYS        (NK),
    .CODE_W          (3),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .key_if (kif)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [NK-1:0] hist_m [$];
  logic [NK-1:0] kn_last_m;
  logic [NK-1:0] db_m;
  int            n_m;
  bit            busy_m;
  bit            settled_m;
  logic          valid_m, held_m, ovr_m;
  logic [2:0]    code_m;

  task automatic model_step();
    logic [NK-1:0] s_new;
    bit emit;
    int idx;
    bit acc;
    bit all_eq;
    if (!rst_n) begin
      hist_m.delete();
      hist_m.push_back({NK{1'b1}});
      n_m = 0; db_m = '0; busy_m = 1; settled_m = 0;
      valid_m = 0; held_m = 0; ovr_m = 0; code_m = '0;
    end else begin
      emit = 0; idx = 0;
      // After reset or a press, nothing is reported until all keys are
      // seen up again with the debounce window full.
      if (busy_m) begin
        if (db_m == 0 && settled_m) busy_m = 0;
      end else if (db_m != 0) begin
        busy_m = 1;
        if ($countones(db_m) == 1) begin
          emit = 1;
          for (int k = 0; k < NK; k++) if (db_m[k]) idx = k;
        end
      end
      acc = valid_m && kif.key_ready;
      ovr_m = 0;
      if (emit) begin
        if (!valid_m || acc) begin code_m = idx[2:0]; valid_m = 1; end
        else ovr_m = 1;
      end else if (acc) valid_m = 0;
      held_m = |db_m;
      // Synchronised sample sequence: first post-reset sample is the reset
      // value of the synchroniser (all "pressed"), then key_n two edges late.
      n_m++;
      s_new = (n_m == 1) ? {NK{1'b1}} : ~kn_last_m;
      kn_last_m = key_n;
      hist_m.push_back(s_new);
      if (hist_m.size() > DEB + 1) void'(hist_m.pop_front());
      all_eq = (hist_m.size() == DEB + 1);
      foreach (hist_m[k]) if (hist_m[k] != s_new) all_eq = 0;
      settled_m = all_eq;
      if (all_eq) db_m = s_new;
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("key_valid", {7'd0, kif.key_valid}, {7'd0, valid_m});
    chk("key_code",  {5'd0, kif.key_code},  {5'd0, code_m});
    chk("key_held",  {7'd0, kif.key_held},  {7'd0, held_m});
    chk("overrun",   {7'd0, kif.overrun},   {7'd0, ovr_m});
    if (kif.key_valid === 1'b1 && prev_valid !== 1'b1) rises++;
    prev_valid = kif.key_valid;
    if (kif.overrun === 1'b1) ovr_cnt++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int r0;
    int o0;
    int r;
    rst_n = 1'b0;
    key_n = {NK{1'b1}};
    kif.key_ready = 1'b1;
    #12;
    chk("rst_valid", {7'd0, kif.key_valid}, 8'd0);
    chk("rst_code",  {5'd0, kif.key_code},  8'd0);
    chk("rst_held",  {7'd0, kif.key_held},  8'd0);
    chk("rst_ovr",   {7'd0, kif.overrun},   8'd0);
    @(negedge clk); rst_n = 1'b1;
    cycles(10);

    // 1: single press, latency and one-cycle valid with ready high
    key_n[3] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (kif.key_valid === 1'b1 && lat == 0) begin
        lat = i;
        chk("t1_code", {5'd0, kif.key_code}, 8'd3);
      end
    end
    chk("t1_latency", 8'(lat), 8'(DEB + 3));
    chk("t1_held", {7'd0, kif.key_held}, 8'd1);
    key_n = {NK{1'b1}};
    cycles(10);
    chk("t1_held_rel", {7'd0, kif.key_held}, 8'd0);

    // 2: bouncing key 1, then held
    r0 = rises;
    for (int i = 0; i < 6; i++) begin
      key_n[1] = ~key_n[1];
      cycles(2);
    end
    chk("t2_bounce_quiet", 8'(rises - r0), 8'd0);
    key_n[1] = 1'b0;
    cycles(10);
    chk("t2_one_code", 8'(rises - r0), 8'd1);
    chk("t2_code", {5'd0, kif.key_code}, 8'd1);
    key_n = {NK{1'b1}};
    cycles(10);

    // 3: slot full, second press dropped with overrun
    kif.key_ready = 1'b0;
    o0 = ovr_cnt;
    key_n[2] = 1'b0; cycles(8);
    key_n = {NK{1'b1}}; cycles(8);
    key_n[4] = 1'b0; cycles(8);
    key_n = {NK{1'b1}}; cycles(8);
    chk("t3_ovr_pulses", 8'(ovr_cnt - o0), 8'd1);
    chk("t3_valid", {7'd0, kif.key_valid}, 8'd1);
    chk("t3_code", {5'd0, kif.key_code}, 8'd2);
    kif.key_ready = 1'b1; cycle();
    kif.key_ready = 1'b0; cycles(5);
    chk("t3_drained", {7'd0, kif.key_valid}, 8'd0);
    chk("t3_code_kept", {5'd0, kif.key_code}, 8'd2);

    // 4: chord gives nothing, then key 5 alone
    kif.key_ready = 1'b1;
    r0 = rises; o0 = ovr_cnt;
    key_n[0] = 1'b0; key_n[5] = 1'b0; cycles(10);
    chk("t4_chord_none", 8'(rises - r0), 8'd0);
    chk("t4_chord_novr", 8'(ovr_cnt - o0), 8'd0);
    key_n = {NK{1'b1}}; cycles(10);
    key_n[5] = 1'b0; cycles(10);
    chk("t4_code5", {5'd0, kif.key_code}, 8'd5);
    chk("t4_one_code", 8'(rises - r0), 8'd1);
    key_n = {NK{1'b1}}; cycles(10);

    // 5: key held through reset is not reported
    key_n[2] = 1'b0; cycles(2);
    rst_n = 1'b0; prev_valid = 1'b0; cycles(2);
    rst_n = 1'b1;
    r0 = rises;
    cycles(12);
    chk("t5_no_code", 8'(rises - r0), 8'd0);
    chk("t5_held", {7'd0, kif.key_held}, 8'd1);
    key_n = {NK{1'b1}}; cycles(10);
    key_n[2] = 1'b0; cycles(10);
    chk("t5_code2", {5'd0, kif.key_code}, 8'd2);
    chk("t5_one_code", 8'(rises - r0), 8'd1);
    key_n = {NK{1'b1}}; cycles(10);

    // 6: async reset clears a pending code mid-cycle
    kif.key_ready = 1'b0;
    key_n[4] = 1'b0; cycles(9);
    chk("t6_pending", {5'd0, kif.key_code}, 8'd4);
    key_n = {NK{1'b1}};
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {7'd0, kif.key_valid}, 8'd0);
    chk("t6_rst_code",  {5'd0, kif.key_code},  8'd0);
    chk("t6_rst_held",  {7'd0, kif.key_held},  8'd0);
    @(negedge clk); rst_n = 1'b1; prev_valid = 1'b0;
    cycles(10);
    key_n[1] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (kif.key_valid === 1'b1 && lat == 0) lat = i;
    end
    chk("t6_latency", 8'(lat), 8'(DEB + 3));
    chk("t6_code1", {5'd0, kif.key_code}, 8'd1);
    key_n = {NK{1'b1}}; cycles(10);
    // accept and emit on the same edge
    key_n[5] = 1'b0; cycles(DEB + 2);
    kif.key_ready = 1'b1; cycle();
    chk("t6_same_valid", {7'd0, kif.key_valid}, 8'd1);
    chk("t6_same_code",  {5'd0, kif.key_code},  8'd5);
    chk("t6_same_novr",  {7'd0, kif.overrun},   8'd0);
    cycle();
    key_n = {NK{1'b1}}; cycles(10);

    // Random presses, chords, chatter and back-pressure
    for (int i = 0; i < 800; i++) begin
      kif.key_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 5)      key_n = {NK{1'b1}};
        else if (r < 9) key_n = ~(6'b000001 << $urandom_range(0, NK - 1));
        else            key_n = 6'($urandom_range(0, 63));
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
